// File: rtl/des_switcher_pkg.sv
// rtl/des_switcher_pkg.sv - shared types and constants for the design switcher
package des_switcher_pkg;

  // Width of the drain/settle counter
  localparam int CNT_W = 8;

  // Switch sequencer states
  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    DRAIN  = 2'd1,
    SETTLE = 2'd2
  } state_t;

endpackage

// File: rtl/des_switcher_if.sv
// rtl/des_switcher_if.sv - per-design IO bus between the switcher and the attached designs
interface des_switcher_if #(
  parameter int NUM_DES = 64,
  parameter int IO_W    = 12
) ();

  logic [NUM_DES-1:0][IO_W-1:0] des_io_in;
  logic [NUM_DES-1:0]           des_reset;
  logic [NUM_DES-1:0][IO_W-1:0] des_io_out;

  // Switcher side: drives design inputs/resets, reads design outputs
  modport master (
    output des_io_in,
    output des_reset,
    input  des_io_out
  );

  // Design side: the mirror view
  modport slave (
    input  des_io_in,
    input  des_reset,
    output des_io_out
  );

endinterface

// File: rtl/des_switcher_sync_chain.sv
// rtl/des_switcher_sync_chain.sv - reset-less multi-flop input synchroniser
module sync_chain #(
  parameter int WIDTH  = 13,
  parameter int STAGES = 3
) (
  input  logic             clock,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [STAGES-1:0][WIDTH-1:0] r_chain;

  // Shift every cycle, reset included, so the chain also carries the reset bit
  always_ff @(posedge clock) begin
    r_chain[0] <= i_d;
    for (int s = 1; s < STAGES; s++) begin
      r_chain[s] <= r_chain[s-1];
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/des_switcher.sv
// rtl/des_switcher.sv - selects one of many attached designs with a drain/settle handover
module des_switcher
  import des_switcher_pkg::*;
#(
  parameter int NUM_DES       = 64,
  parameter int IO_W          = 12,
  parameter int SYNC_STAGES   = 3,
  parameter int SETTLE_CYCLES = 8,
  localparam int SW           = $clog2(NUM_DES)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [IO_W-1:0] io_in,
  output logic [IO_W-1:0] io_out,
  input  logic [SW-1:0]   des_sel,
  input  logic            hold_if_not_sel,
  input  logic            sync_inputs,
  output logic            switching,
  output logic [SW-1:0]   active_sel,
  des_switcher_if.master  des_bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [SW-1:0]      r_cur;
  logic [SW-1:0]      w_cur_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [SW-1:0]      r_sel_q;

  logic [IO_W:0]      w_sync_out;
  logic               w_src_rst;
  logic [IO_W-1:0]    w_src_in;
  logic               w_cur_valid;

  logic [NUM_DES-1:0][IO_W-1:0] w_des_io_in;
  logic [NUM_DES-1:0]           w_des_reset;

  sync_chain #(
    .WIDTH  (IO_W + 1),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clock (clock),
    .i_d   ({reset, io_in}),
    .o_q   (w_sync_out)
  );

  assign w_src_rst   = sync_inputs ? w_sync_out[IO_W]        : reset;
  assign w_src_in    = sync_inputs ? w_sync_out[IO_W-1:0]    : io_in;
  // An out-of-range selection connects nothing
  assign w_cur_valid = ({1'b0, r_cur} < (SW+1)'(NUM_DES));

  // Request register and sequencer state; reset parks in SETTLE on design 0
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sel_q <= '0;
      r_state <= SETTLE;
      r_cur   <= '0;
      r_cnt   <= '0;
    end else begin
      r_sel_q <= des_sel;
      r_state <= w_state_nxt;
      r_cur   <= w_cur_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state: DRAIN latches the target only on exit; SETTLE restarts on a new request
  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ACTIVE: begin
        if (r_sel_q != r_cur) begin
          w_state_nxt = DRAIN;
          w_cnt_nxt   = '0;
        end
      end
      DRAIN: begin
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = SETTLE;
          w_cur_nxt   = r_sel_q;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + 1'b1;
        end
      end
      SETTLE: begin
        if (r_sel_q != r_cur) begin
          w_state_nxt = DRAIN;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ACTIVE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = SETTLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Per-design routing: cur is held while switching, others follow hold_if_not_sel
  always_comb begin
    w_des_io_in = '0;
    w_des_reset = '0;
    for (int i = 0; i < NUM_DES; i++) begin
      if ((w_cur_valid && (r_cur == SW'(i))) ? (r_state != ACTIVE) : hold_if_not_sel) begin
        w_des_io_in[i] = '0;
        w_des_reset[i] = 1'b1;
      end else begin
        w_des_io_in[i] = w_src_in;
        w_des_reset[i] = w_src_rst;
      end
    end
  end

  assign des_bus.des_io_in = w_des_io_in;
  assign des_bus.des_reset = w_des_reset;

  assign io_out     = ((r_state == ACTIVE) && w_cur_valid) ? des_bus.des_io_out[r_cur] : '0;
  assign switching  = (r_state != ACTIVE);
  assign active_sel = r_cur;

endmodule

// File: tb/tb_des_switcher.sv
// tb/tb_des_switcher.sv - directed self-checking bench for des_switcher
module tb_des_switcher;

  logic        clock = 1'b0;
  logic        rst_a, rst_b;
  logic [11:0] io_in;
  logic        hold, sync;
  logic [5:0]  sel_a, sel_b;
  logic [11:0] out_a, out_b;
  logic        sw_a, sw_b;
  logic [5:0]  act_a, act_b;

  int checks = 0;
  int errors = 0;

  logic [63:0][11:0] exp_in_a;
  logic [63:0]       exp_rst_a;
  logic [47:0][11:0] exp_in_b;
  logic [47:0]       exp_rst_b;

  always #5 clock = ~clock;

  des_switcher_if #(.NUM_DES(64), .IO_W(12)) bus_a ();
  des_switcher_if #(.NUM_DES(48), .IO_W(12)) bus_b ();

  des_switcher #(.NUM_DES(64), .IO_W(12), .SYNC_STAGES(3), .SETTLE_CYCLES(8)) u_a (
    .clock(clock), .reset(rst_a), .io_in(io_in), .io_out(out_a), .des_sel(sel_a),
    .hold_if_not_sel(hold), .sync_inputs(sync), .switching(sw_a), .active_sel(act_a),
    .des_bus(bus_a.master)
  );

  des_switcher #(.NUM_DES(48), .IO_W(12), .SYNC_STAGES(3), .SETTLE_CYCLES(8)) u_b (
    .clock(clock), .reset(rst_b), .io_in(io_in), .io_out(out_b), .des_sel(sel_b),
    .hold_if_not_sel(hold), .sync_inputs(sync), .switching(sw_b), .active_sel(act_b),
    .des_bus(bus_b.master)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    io_in = '0; hold = 1'b0; sync = 1'b0;
    sel_a = '0; sel_b = '0;
    for (int i = 0; i < 64; i++) bus_a.des_io_out[i] = 12'h100 + 12'(i);
    for (int i = 0; i < 48; i++) bus_b.des_io_out[i] = 12'h200 + 12'(i);

    // reset state
    tick(3);
    check("rst_io_out_a", out_a, 12'h000);
    check("rst_switching_a", sw_a, 1'b1);
    check("rst_active_sel_a", act_a, 6'd0);
    check("rst_io_out_b", out_b, 12'h000);
    check("rst_switching_b", sw_b, 1'b1);

    // post-reset settle on design 0
    rst_a = 1'b0; rst_b = 1'b0;
    tick(7);
    check("post_rst_still_settle", sw_a, 1'b1);
    tick(1);
    check("post_rst_active_a", sw_a, 1'b0);
    check("post_rst_io_out_a", out_a, 12'h100);
    check("post_rst_active_b", sw_b, 1'b0);
    check("post_rst_io_out_b", out_b, 12'h200);

    // switch 0 -> 5 latency, hold_if_not_sel=0
    io_in = 12'h3C3;
    sel_a = 6'd5;
    tick(1);
    check("t1_still_active", sw_a, 1'b0);
    for (int n = 2; n <= 17; n++) begin
      tick(1);
      check("switch_io_out_zero", out_a, 12'h000);
      check("switch_switching", sw_a, 1'b1);
      if (n == 5) begin
        for (int i = 0; i < 64; i++) exp_in_a[i] = (i == 0) ? 12'h3C3 : 12'h3C3;
        exp_in_a[0] = 12'h000;
        exp_rst_a = 64'h1;
        check("drain_hold_cur_rst", bus_a.des_reset, exp_rst_a);
        check("drain_hold_cur_in", bus_a.des_io_in, exp_in_a);
      end
    end
    tick(1);
    check("t18_active", sw_a, 1'b0);
    check("t18_active_sel", act_a, 6'd5);
    check("t18_io_out", out_a, 12'h105);
    bus_a.des_io_out[5] = 12'h5A5;
    #1;
    check("io_out_comb_follow", out_a, 12'h5A5);

    // hold_if_not_sel in ACTIVE
    hold = 1'b1;
    #1;
    for (int i = 0; i < 64; i++) exp_in_a[i] = 12'h000;
    exp_in_a[5] = 12'h3C3;
    exp_rst_a = 64'hFFFF_FFFF_FFFF_FFDF;
    check("hold_rst", bus_a.des_reset, exp_rst_a);
    check("hold_in", bus_a.des_io_in, exp_in_a);
    hold = 1'b0;
    #1;
    for (int i = 0; i < 64; i++) exp_in_a[i] = 12'h3C3;
    exp_rst_a = 64'h0;
    check("nohold_rst", bus_a.des_reset, exp_rst_a);
    check("nohold_in", bus_a.des_io_in, exp_in_a);

    // synchroniser latency
    io_in = 12'h000;
    sync = 1'b1;
    tick(4);
    check("sync_flushed", bus_a.des_io_in[5], 12'h000);
    io_in = 12'hABC;
    tick(2);
    check("sync_not_yet", bus_a.des_io_in[5], 12'h000);
    tick(1);
    check("sync_3_cycles", bus_a.des_io_in[5], 12'hABC);
    check("sync_rst_bit", bus_a.des_reset[5], 1'b0);
    sync = 1'b0;
    io_in = 12'h123;
    #1;
    check("raw_same_cycle", bus_a.des_io_in[5], 12'h123);

    // 3 -> 7 -> 3 inside DRAIN: target taken at exit is 3
    sel_a = 6'd3;
    tick(3);
    sel_a = 6'd7;
    tick(2);
    sel_a = 6'd3;
    tick(4);
    check("drain_cur_unchanged", act_a, 6'd5);
    tick(1);
    check("drain_exit_target", act_a, 6'd3);
    check("drain_exit_switching", sw_a, 1'b1);
    tick(8);
    check("toggle_active", sw_a, 1'b0);
    check("toggle_active_sel", act_a, 6'd3);

    // 5 -> 9 during SETTLE restarts DRAIN
    hold = 1'b1;
    sel_a = 6'd5;
    tick(12);
    check("settle_cur5", act_a, 6'd5);
    check("settle_switching", sw_a, 1'b1);
    sel_a = 6'd9;
    tick(2);
    check("redrain_cur", act_a, 6'd5);
    check("redrain_switching", sw_a, 1'b1);
    check("redrain_hold9_rst", bus_a.des_reset[9], 1'b1);
    check("redrain_hold9_in", bus_a.des_io_in[9], 12'h000);
    check("redrain_hold5_rst", bus_a.des_reset[5], 1'b1);
    tick(15);
    check("redrain_u17", sw_a, 1'b1);
    tick(1);
    check("redrain_u18_active", sw_a, 1'b0);
    check("redrain_u18_sel", act_a, 6'd9);
    check("redrain_u18_io_out", out_a, 12'h109);
    hold = 1'b0;

    // out-of-range selection on the 48-design instance
    sel_b = 6'd50;
    tick(17);
    check("oor_switching", sw_b, 1'b1);
    tick(1);
    check("oor_active", sw_b, 1'b0);
    check("oor_active_sel", act_b, 6'd50);
    check("oor_io_out", out_b, 12'h000);
    for (int i = 0; i < 48; i++) exp_in_b[i] = 12'h123;
    exp_rst_b = 48'h0;
    check("oor_nohold_rst", bus_b.des_reset, exp_rst_b);
    check("oor_nohold_in", bus_b.des_io_in, exp_in_b);
    hold = 1'b1;
    #1;
    for (int i = 0; i < 48; i++) exp_in_b[i] = 12'h000;
    exp_rst_b = 48'hFFFF_FFFF_FFFF;
    check("oor_hold_rst", bus_b.des_reset, exp_rst_b);
    check("oor_hold_in", bus_b.des_io_in, exp_in_b);
    hold = 1'b0;

    // reset mid-SETTLE aborts the switch, then re-switches to the pending request
    sel_b = 6'd7;
    tick(12);
    check("mid_settle_sel", act_b, 6'd7);
    check("mid_settle_switching", sw_b, 1'b1);
    rst_b = 1'b1;
    tick(1);
    check("abort_switching", sw_b, 1'b1);
    check("abort_active_sel", act_b, 6'd0);
    check("abort_io_out", out_b, 12'h000);
    tick(1);
    rst_b = 1'b0;
    tick(17);
    check("reswitch_r17", sw_b, 1'b1);
    tick(1);
    check("reswitch_r18_active", sw_b, 1'b0);
    check("reswitch_r18_sel", act_b, 6'd7);
    check("reswitch_r18_io_out", out_b, 12'h207);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
